// File: rtl/core_scheduler.sv
// core_scheduler: per-core instruction sequencer; define SCHED_WAIT_TIMEOUT_EN to add a WAIT watchdog
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
`ifdef SCHED_WAIT_TIMEOUT_EN
  , parameter int WAIT_TIMEOUT = 255
`endif
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           start,
  input  logic [THREADS_PER_BLOCK-1:0]                   thread_enable,
  input  logic [2:0]                                     fetcher_state,
  input  logic                                           decoded_mem_read_enable,
  input  logic                                           decoded_mem_write_enable,
  input  logic [1:0]                                     decoded_reg_input_mux,
  input  logic                                           decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]                 lsu_state,
  input  logic                                           gemm_done,
  input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                                     core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]               current_pc,
`ifdef SCHED_WAIT_TIMEOUT_EN
  output logic                                           wait_timeout,
`endif
  output logic                                           done
);
  typedef enum logic [2:0] {
    IDLE = 3'b000, FETCH = 3'b001, DECODE = 3'b010, REQUEST = 3'b011,
    WAIT = 3'b100, EXECUTE = 3'b101, UPDATE = 3'b110, DONE = 3'b111
  } state_t;
  state_t state, next;
  logic gemm_seen, lsu_busy, ready, timeout_hit;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_sel;
  assign core_state = state;
  assign done = state == DONE;
  assign ready = (!(decoded_mem_read_enable || decoded_mem_write_enable) || !lsu_busy) &&
                 (decoded_reg_input_mux != 2'b11 || gemm_seen);
  // an enabled lane is busy while its LSU is REQUESTING or WAITING (the two bits differ)
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++)
      lsu_busy = lsu_busy | (thread_enable[i] & ^lsu_state[2*i +: 2]);
  end
  // next PC comes from the lowest-indexed enabled lane
  always_comb begin
    pc_sel = '0;
    for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--)
      if (thread_enable[i]) pc_sel = next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
  end
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = fetcher_state == 3'b010 ? DECODE : FETCH;
      DECODE:  next = REQUEST;
      REQUEST: next = WAIT;
      WAIT:    next = ready ? EXECUTE : timeout_hit ? DONE : WAIT;
      EXECUTE: next = UPDATE;
      UPDATE:  next = (decoded_ret || thread_enable == '0) ? DONE : FETCH;
      DONE:    next = DONE;
      default: next = IDLE;
    endcase
  end
  // state, PC and GEMM-completion flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      current_pc <= '0;
      gemm_seen <= 1'b0;
    end else begin
      state <= next;
      if (state == UPDATE && next == FETCH) current_pc <= pc_sel;
      if (state == WAIT && next == EXECUTE) gemm_seen <= 1'b0;
      else if (gemm_done && (state == REQUEST || state == WAIT)) gemm_seen <= 1'b1;
    end
  end
`ifdef SCHED_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(WAIT_TIMEOUT + 1) > 8 ? $clog2(WAIT_TIMEOUT + 1) : 8;
  logic [TW-1:0] wait_cnt;
  assign timeout_hit = !ready && wait_cnt == TW'(WAIT_TIMEOUT - 1);
  // counts WAIT cycles (zero on entry); sticky flag when the budget runs out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      wait_timeout <= 1'b0;
    end else begin
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      if (state == WAIT && timeout_hit) wait_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif
endmodule

// File: tb/tb_core_scheduler.sv
// tb_core_scheduler: directed-vector bench for core_scheduler
module tb_core_scheduler;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [3:0] thread_enable = 4'b0001;
  logic [2:0] fetcher_state = 3'b000;
  logic decoded_mem_read_enable = 1'b0, decoded_mem_write_enable = 1'b0, decoded_ret = 1'b0;
  logic [1:0] decoded_reg_input_mux = 2'b00;
  logic [7:0] lsu_state = 8'h00;
  logic gemm_done = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic [2:0] core_state;
  logic [7:0] current_pc;
  logic done;
  int vectors = 0, miscompares = 0;
`ifdef SCHED_WAIT_TIMEOUT_EN
  logic wait_timeout;
`endif

  core_scheduler #(
    .THREADS_PER_BLOCK(4),
    .PROGRAM_MEM_ADDR_BITS(8)
`ifdef SCHED_WAIT_TIMEOUT_EN
    , .WAIT_TIMEOUT(10)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .thread_enable(thread_enable),
    .fetcher_state(fetcher_state),
    .decoded_mem_read_enable(decoded_mem_read_enable),
    .decoded_mem_write_enable(decoded_mem_write_enable),
    .decoded_reg_input_mux(decoded_reg_input_mux),
    .decoded_ret(decoded_ret),
    .lsu_state(lsu_state),
    .gemm_done(gemm_done),
    .next_pc(next_pc),
    .core_state(core_state),
    .current_pc(current_pc),
`ifdef SCHED_WAIT_TIMEOUT_EN
    .wait_timeout(wait_timeout),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_request(input string tag);
    fetcher_state = 3'b010;
    tick();
    check({tag, " decode"}, 32'(core_state), 32'h2);
    fetcher_state = 3'b000;
    tick();
    check({tag, " request"}, 32'(core_state), 32'h3);
  endtask

  task automatic finish_instr(input string tag, input logic [7:0] pc);
    tick();
    check({tag, " execute"}, 32'(core_state), 32'h5);
    tick();
    check({tag, " update"}, 32'(core_state), 32'h6);
    tick();
    check({tag, " refetch"}, 32'(core_state), 32'h1);
    check({tag, " pc"}, 32'(current_pc), 32'(pc));
  endtask

  initial begin
    repeat (2) tick();
    check("rst state", 32'(core_state), 32'h0);
    check("rst pc", 32'(current_pc), 32'h0);
    check("rst done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick();
    check("idle hold", 32'(core_state), 32'h0);
    // ALU instruction, fetch takes two cycles
    next_pc = 32'h0000_0001;
    start = 1'b1;
    tick();
    check("alu fetch1", 32'(core_state), 32'h1);
    check("alu pc0", 32'(current_pc), 32'h0);
    start = 1'b0;
    tick();
    check("alu fetch2", 32'(core_state), 32'h1);
    to_request("alu");
    tick();
    check("alu wait", 32'(core_state), 32'h4);
    finish_instr("alu", 8'h01);
    // LDR, lanes 0 and 2 enabled, lane2 busy for 6 WAIT cycles, lane1 stuck but disabled
    thread_enable = 4'b0101;
    next_pc = 32'h20_77_77_05;
    decoded_mem_read_enable = 1'b1;
    lsu_state = 8'b00_10_01_00;
    to_request("ldr");
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("ldr wait%0d", k), 32'(core_state), 32'h4);
    end
    lsu_state = 8'b00_11_01_00;
    finish_instr("ldr", 8'h05);
    decoded_mem_read_enable = 1'b0;
    lsu_state = 8'h00;
    // GEMM, completion pulse during REQUEST; lane1 is the lowest enabled lane
    thread_enable = 4'b0110;
    next_pc = 32'h99_99_40_AA;
    decoded_reg_input_mux = 2'b11;
    to_request("gemm_req");
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    check("gemm_req wait", 32'(core_state), 32'h4);
    finish_instr("gemm_req", 8'h40);
    // GEMM, completion pulse in the 5th WAIT cycle; flag is seen the cycle after
    next_pc = 32'h00_00_41_00;
    to_request("gemm_w");
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("gemm_w wait%0d", k), 32'(core_state), 32'h4);
    end
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    check("gemm_w wait6", 32'(core_state), 32'h4);
    finish_instr("gemm_w", 8'h41);
    decoded_reg_input_mux = 2'b00;
    // RET ends the block, PC held, start ignored
    decoded_ret = 1'b1;
    next_pc = 32'h55_55_55_55;
    to_request("ret");
    tick();
    tick();
    tick();
    check("ret update", 32'(core_state), 32'h6);
    tick();
    check("ret done state", 32'(core_state), 32'h7);
    check("ret done", 32'(done), 32'h1);
    check("ret pc held", 32'(current_pc), 32'h41);
    start = 1'b1;
    tick();
    check("done start1", 32'(core_state), 32'h7);
    start = 1'b0;
    tick();
    check("done start0", 32'(core_state), 32'h7);
    decoded_ret = 1'b0;
    // async reset while stuck in WAIT
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    thread_enable = 4'b0001;
    next_pc = 32'h0000_0033;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run2 fetch", 32'(core_state), 32'h1);
    to_request("run2");
    tick();
    finish_instr("run2", 8'h33);
    decoded_mem_write_enable = 1'b1;
    lsu_state = 8'b00_00_00_01;
    to_request("str");
    tick();
    tick();
    check("str wait", 32'(core_state), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async state", 32'(core_state), 32'h0);
    check("async pc", 32'(current_pc), 32'h0);
    check("async done", 32'(done), 32'h0);
    tick();
    reset_n = 1'b1;
    decoded_mem_write_enable = 1'b0;
    lsu_state = 8'h00;
    // no enabled lanes behaves like RET
    thread_enable = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    to_request("nolane");
    tick();
    tick();
    tick();
    tick();
    check("nolane done", 32'(core_state), 32'h7);
    check("nolane pc", 32'(current_pc), 32'h0);
`ifdef SCHED_WAIT_TIMEOUT_EN
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    thread_enable = 4'b0001;
    decoded_mem_read_enable = 1'b1;
    lsu_state = 8'b00_00_00_10;
    start = 1'b1;
    tick();
    start = 1'b0;
    to_request("tmo");
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("tmo wait%0d", k), 32'(core_state), 32'h4);
      check($sformatf("tmo flag%0d", k), 32'(wait_timeout), 32'h0);
    end
    tick();
    check("tmo done state", 32'(core_state), 32'h7);
    check("tmo done", 32'(done), 32'h1);
    check("tmo flag", 32'(wait_timeout), 32'h1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
